ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 STARVE_MAX, default 4: consecutive DMA grants allowed while a CPU request waits; legal range 1..15.
REQ-002 clk_sys  in  1  system clock, 96 MHz; all logic on posedge.
REQ-003 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-004 ldr_req  in  1  loader write request (download/erase), level, held until ack.
REQ-005 ldr_addr  in  25  loader byte address.
REQ-006 ldr_din  in  8  loader write data.
REQ-007 dma_req  in  1  video DMA read request, level, held until ack.
REQ-008 dma_addr  in  16  DMA byte address.
REQ-009 cpu_req  in  1  CPU access request, level, held until ack.
REQ-010 cpu_we  in  1  1 = CPU write, 0 = CPU read.
REQ-011 cpu_addr  in  16  CPU byte address.
REQ-012 cpu_din  in  8  CPU write data.
REQ-013 ext_sel  in  1  CPU access targets the extended-ROM window.
REQ-014 ext_addr  in  19  extended-ROM offset.
REQ-015 ack  out  3  one-cycle grant-complete pulse: [2] loader, [1] DMA, [0] CPU.
REQ-016 rd_data  out  8  read data; valid in the ack cycle and held until the next read completes.
REQ-017 mem_addr  out  25  SDRAM controller address.
REQ-018 mem_din  out  8  SDRAM write data.
REQ-019 mem_we  out  1  one-cycle write strobe.
REQ-020 mem_rd  out  1  one-cycle read strobe.
REQ-021 mem_ready  in  1  SDRAM controller access complete, one-cycle pulse.
REQ-022 mem_dout  in  8  SDRAM read data, valid when mem_ready is high.

Function
REQ-023 The FSM SHALL have the states IDLE, ISSUE and WAIT, with transitions IDLE->ISSUE on any request, ISSUE->WAIT unconditionally, and WAIT->IDLE on mem_ready.
REQ-024 Arbitration SHALL occur in IDLE only, with fixed priority loader > DMA > CPU; the winner's address and data SHALL be latched on IDLE->ISSUE.
REQ-025 Starvation guard: if cpu_req is high and the DMA has been granted STARVE_MAX times in a row, the CPU SHALL win over the DMA; the counter SHALL clear on any CPU grant or when cpu_req is low; the loader always wins.
REQ-026 In ISSUE, exactly one of mem_we/mem_rd SHALL pulse for one cycle (loader: we; DMA: rd; CPU: per cpu_we); mem_addr and mem_din SHALL be stable from ISSUE until leaving WAIT.
REQ-027 On mem_ready in WAIT, ack[winner] SHALL pulse in the same cycle and, for reads, rd_data SHALL capture mem_dout.
REQ-028 Minimum latency from request to ack SHALL be 3 cycles (IDLE, ISSUE, WAIT with mem_ready=1).
REQ-029 Normal address mapping SHALL be {9'b0, addr16}; the loader address SHALL pass through unmodified.
REQ-030 A request dropped mid-access SHALL NOT abort the access: the access completes and ack still pulses.
REQ-031 mem_ready received outside WAIT SHALL be ignored.
REQ-032 A new grant SHALL be possible in the cycle after ack (back-to-back accesses every 3 cycles).

Reset
REQ-033 While reset_n is low: state = IDLE; ack, mem_we, mem_rd = 0; mem_addr, mem_din, rd_data = 0; starvation counter = 0.
REQ-034 Reset asserted mid-access SHALL abandon the access with no ack; after release, a still-asserted request SHALL re-arbitrate.

Configuration
REQ-035 With RAM_ARB_EXTROM_EN defined, a CPU access with ext_sel=1 SHALL map to {3'b100, 3'b0, ext_addr} and SHALL be forced to a read.
REQ-036 Without RAM_ARB_EXTROM_EN, ext_sel and ext_addr SHALL be ignored and all CPU accesses SHALL use the normal mapping.

Structure
REQ-037 Package ram_arb_pkg SHALL hold the state enum, the requester index constants (LDR=2, DMA=1, CPU=0) and the EXTROM_BASE constant 3'b100.
REQ-038 The priority/starvation selection SHALL be one sub-module, ram_arb_prio, which is purely combinational plus the counter; the FSM stays in ram_arbiter.

Verification
REQ-039 cpu_req read at 16'h1234, mem_ready 1 cycle after ISSUE, mem_dout=8'hA5 -> mem_rd pulse, mem_addr=25'h0001234, ack=3'b001, rd_data=8'hA5.
REQ-040 ldr_req and dma_req asserted in the same cycle -> loader served first (mem_we, ack[2]), then DMA (ack[1]).
REQ-041 dma_req held continuously with cpu_req also high, STARVE_MAX=4 -> 4 DMA acks, then 1 CPU ack, then DMA resumes.
REQ-042 RAM_ARB_EXTROM_EN defined, CPU write with ext_sel=1, ext_addr=19'h7FFFF -> mem_rd (not mem_we) to 25'h107FFFF.
REQ-043 reset_n pulled low during WAIT, then released with cpu_req high -> no ack during reset; the access is reissued with a fresh mem_rd and ack follows.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared FSM encodings, requester indices and command type for the SDRAM port arbiter.
package ram_arb_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ISSUE = 2'd1;
  localparam state_t S_WAIT  = 2'd2;

  localparam int LDR = 2;
  localparam int DMA = 1;
  localparam int CPU = 0;

  localparam logic [2:0] EXTROM_BASE = 3'b100;

  typedef struct packed {
    logic        we;
    logic [24:0] addr;
    logic [7:0]  din;
  } mem_cmd_t;

  function automatic logic [24:0] map16(input logic [15:0] a);
    return {9'b0, a};
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and SDRAM-controller signals of the arbiter; slave = arbiter view, master = environment view.
interface ram_arbiter_if;
  logic        ldr_req;
  logic [24:0] ldr_addr;
  logic [7:0]  ldr_din;
  logic        dma_req;
  logic [15:0] dma_addr;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        ext_sel;
  logic [18:0] ext_addr;
  logic [2:0]  ack;
  logic [7:0]  rd_data;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_rd;
  logic        mem_ready;
  logic [7:0]  mem_dout;

  modport slave (
    input  ldr_req, ldr_addr, ldr_din, dma_req, dma_addr,
           cpu_req, cpu_we, cpu_addr, cpu_din, ext_sel, ext_addr,
           mem_ready, mem_dout,
    output ack, rd_data, mem_addr, mem_din, mem_we, mem_rd
  );

  modport master (
    output ldr_req, ldr_addr, ldr_din, dma_req, dma_addr,
           cpu_req, cpu_we, cpu_addr, cpu_din, ext_sel, ext_addr,
           mem_ready, mem_dout,
    input  ack, rd_data, mem_addr, mem_din, mem_we, mem_rd
  );
endinterface

// File: rtl/ram_arbiter_prio.sv
// Fixed-priority winner select (loader > DMA > CPU) with a counter that lets a
// waiting CPU overtake the DMA after STARVE_MAX consecutive DMA grants.
module ram_arb_prio
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ldr_req_i,
  input  logic       dma_req_i,
  input  logic       cpu_req_i,
  input  logic       grant_i,
  output logic [2:0] win_o
);

  logic [3:0] starve_q, starve_d;
  logic       cpu_first;

  assign cpu_first = cpu_req_i && (starve_q >= 4'(STARVE_MAX));

  always_comb begin
    win_o = '0;
    if (ldr_req_i)                     win_o[LDR] = 1'b1;
    else if (dma_req_i && !cpu_first)  win_o[DMA] = 1'b1;
    else if (cpu_req_i)                win_o[CPU] = 1'b1;
  end

  // Loader grants leave the run length untouched; only the CPU side resets it.
  always_comb begin
    starve_d = starve_q;
    if (!cpu_req_i)                                        starve_d = '0;
    else if (grant_i && win_o[CPU])                        starve_d = '0;
    else if (grant_i && win_o[DMA] && starve_q != 4'hF)    starve_d = starve_q + 4'd1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) starve_q <= '0;
    else          starve_q <= starve_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// SDRAM port arbiter: IDLE/ISSUE/WAIT sequencer around ram_arb_prio.
// Define RAM_ARB_EXTROM_EN to map CPU ext_sel accesses into the read-only extended-ROM window.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic          clk_sys,
  input logic          reset_n,
  ram_arbiter_if.slave bus
);

  state_t     state_q, state_d;
  mem_cmd_t   cmd_d, cmd_q;
  logic [2:0] win, own_q;
  logic [7:0] rd_d, rd_q;
  logic       we_stb_q, rd_stb_q;
  logic       grant, done;

  assign grant = (state_q == S_IDLE) && (bus.ldr_req || bus.dma_req || bus.cpu_req);
  assign done  = (state_q == S_WAIT) && bus.mem_ready;

  ram_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ldr_req_i (bus.ldr_req),
    .dma_req_i (bus.dma_req),
    .cpu_req_i (bus.cpu_req),
    .grant_i   (grant),
    .win_o     (win)
  );

  // Candidate command of the current winner; only latched on a grant.
  always_comb begin
    cmd_d.we   = bus.cpu_we;
    cmd_d.addr = map16(bus.cpu_addr);
    cmd_d.din  = bus.cpu_din;
`ifdef RAM_ARB_EXTROM_EN
    if (bus.ext_sel) begin
      cmd_d.we   = 1'b0;
      cmd_d.addr = {EXTROM_BASE, 3'b000, bus.ext_addr};
    end
`endif
    if (win[LDR]) begin
      cmd_d.we   = 1'b1;
      cmd_d.addr = bus.ldr_addr;
      cmd_d.din  = bus.ldr_din;
    end else if (win[DMA]) begin
      cmd_d.we   = 1'b0;
      cmd_d.addr = map16(bus.dma_addr);
      cmd_d.din  = '0;
    end
  end

`ifndef RAM_ARB_EXTROM_EN
  logic unused_ext;
  assign unused_ext = ^{bus.ext_sel, bus.ext_addr};
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.mem_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data passes straight through in the ack cycle and is held afterwards.
  assign rd_d = (done && !cmd_q.we) ? bus.mem_dout : rd_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      own_q    <= '0;
      rd_q     <= '0;
      we_stb_q <= 1'b0;
      rd_stb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_stb_q <= grant && cmd_d.we;
      rd_stb_q <= grant && !cmd_d.we;
      rd_q     <= rd_d;
      if (grant) begin
        cmd_q <= cmd_d;
        own_q <= win;
      end
    end
  end

  assign bus.mem_we   = we_stb_q;
  assign bus.mem_rd   = rd_stb_q;
  assign bus.mem_addr = cmd_q.addr;
  assign bus.mem_din  = cmd_q.din;
  assign bus.ack      = done ? own_q : 3'b000;
  assign bus.rd_data  = rd_d;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: SDRAM responder model, strobe/ack monitor, one task per scenario.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if bus();
  ram_arbiter #(.STARVE_MAX(4)) dut (.clk_sys(clk), .reset_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit         resp_en   = 1'b1;
  int         rdy_dly   = 0;
  logic [7:0] dout_val  = 8'h00;
  logic       resp_rdy  = 1'b0;
  logic [7:0] resp_dout = 8'h00;
  logic       stray_rdy = 1'b0;

  assign bus.mem_ready = resp_rdy | stray_rdy;
  assign bus.mem_dout  = resp_dout;

  typedef struct packed { logic we; logic rd; logic [24:0] addr; logic [7:0] din; } iss_t;
  typedef struct packed { logic [2:0] ack; logic [7:0] data; logic [31:0] cyc; } ackr_t;
  iss_t  iss_q[$];
  ackr_t ack_q[$];

  // SDRAM controller model: mem_ready rdy_dly cycles after the first WAIT cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (resp_en && (bus.mem_rd || bus.mem_we)) begin
        repeat (rdy_dly) @(posedge clk);
        @(posedge clk); #1;
        resp_rdy = 1'b1; resp_dout = dout_val;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.mem_we || bus.mem_rd) iss_q.push_back({bus.mem_we, bus.mem_rd, bus.mem_addr, bus.mem_din});
      if (bus.ack != 3'b000)        ack_q.push_back({bus.ack, bus.rd_data, 32'(cyc)});
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    int i = 0;
    while (ack_q.size() < n && i < budget) begin tick(); i++; end
    ok = (ack_q.size() >= n);
  endtask

  task automatic clr();
    iss_q.delete(); ack_q.delete();
  endtask

  task automatic test_reset();
    bus.cpu_req = 1'b1; bus.cpu_addr = 16'h0055;
    tick(3);
    total++; if (bus.ack !== 3'b000)     begin bad++; $display("FAIL reset_ack: got %b want 000", bus.ack); end
    total++; if (bus.mem_we !== 1'b0)    begin bad++; $display("FAIL reset_mem_we: got %b want 0", bus.mem_we); end
    total++; if (bus.mem_rd !== 1'b0)    begin bad++; $display("FAIL reset_mem_rd: got %b want 0", bus.mem_rd); end
    total++; if (bus.mem_addr !== 25'h0) begin bad++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
    total++; if (bus.mem_din !== 8'h0)   begin bad++; $display("FAIL reset_mem_din: got %h want 0", bus.mem_din); end
    total++; if (bus.rd_data !== 8'h0)   begin bad++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    bus.cpu_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_cpu_read();
    bit ok; int c0;
    clr();
    dout_val = 8'hA5; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_din = 8'h77;
    bus.cpu_req = 1'b1; c0 = cyc;
    wait_acks(1, 20, ok);
    bus.cpu_req = 1'b0;
    total++; if (!ok) begin bad++; $display("FAIL cpu_rd_timeout: got no ack want ack"); end
    total++; if (iss_q.size() != 1 || {iss_q[0].we, iss_q[0].rd} !== 2'b01)
      begin bad++; $display("FAIL cpu_rd_strobe: got n=%0d we/rd=%b want n=1 01", iss_q.size(), iss_q.size() ? {iss_q[0].we, iss_q[0].rd} : 2'bxx); end
    total++; if (iss_q.size() != 1 || iss_q[0].addr !== 25'h0001234)
      begin bad++; $display("FAIL cpu_rd_addr: got %h want 0001234", iss_q.size() ? iss_q[0].addr : 25'hx); end
    total++; if (!ok || ack_q[0].ack !== 3'b001) begin bad++; $display("FAIL cpu_rd_ack: got %b want 001", ok ? ack_q[0].ack : 3'bx); end
    total++; if (!ok || ack_q[0].data !== 8'hA5) begin bad++; $display("FAIL cpu_rd_data: got %h want a5", ok ? ack_q[0].data : 8'hx); end
    // Request sampled in IDLE, ack seen two cycles later in WAIT: three cycles inclusive.
    total++; if (!ok || int'(ack_q[0].cyc) - c0 != 2) begin bad++; $display("FAIL cpu_rd_latency: got %0d want 2", ok ? int'(ack_q[0].cyc) - c0 : -1); end
    tick();
    total++; if (bus.rd_data !== 8'hA5 || bus.ack !== 3'b000)
      begin bad++; $display("FAIL cpu_rd_hold: got rd=%h ack=%b want a5 000", bus.rd_data, bus.ack); end
    tick(3);
  endtask

  task automatic test_ldr_dma();
    bit ok;
    clr();
    dout_val = 8'h3C;
    bus.ldr_addr = 25'h1ABCDEF; bus.ldr_din = 8'h5A; bus.dma_addr = 16'hBEEF;
    bus.ldr_req = 1'b1; bus.dma_req = 1'b1;
    wait_acks(1, 20, ok);
    bus.ldr_req = 1'b0;
    total++; if (!ok || ack_q[0].ack !== 3'b100) begin bad++; $display("FAIL ldr_first_ack: got %b want 100", ok ? ack_q[0].ack : 3'bx); end
    total++; if (iss_q.size() < 1 || iss_q[0] !== {1'b1, 1'b0, 25'h1ABCDEF, 8'h5A})
      begin bad++; $display("FAIL ldr_cmd: got %h want %h", iss_q.size() ? iss_q[0] : 35'hx, {1'b1, 1'b0, 25'h1ABCDEF, 8'h5A}); end
    wait_acks(2, 20, ok);
    bus.dma_req = 1'b0;
    total++; if (!ok || ack_q[1].ack !== 3'b010) begin bad++; $display("FAIL dma_second_ack: got %b want 010", ok ? ack_q[1].ack : 3'bx); end
    total++; if (iss_q.size() < 2 || {iss_q[1].we, iss_q[1].rd, iss_q[1].addr} !== {2'b01, 25'h000BEEF})
      begin bad++; $display("FAIL dma_cmd: got %h want %h", iss_q.size() > 1 ? {iss_q[1].we, iss_q[1].rd, iss_q[1].addr} : 27'hx, {2'b01, 25'h000BEEF}); end
    total++; if (!ok || ack_q[1].data !== 8'h3C) begin bad++; $display("FAIL dma_rd_data: got %h want 3c", ok ? ack_q[1].data : 8'hx); end
    total++; if (!ok || ack_q[1].cyc - ack_q[0].cyc != 3)
      begin bad++; $display("FAIL ldr_dma_spacing: got %0d want 3", ok ? int'(ack_q[1].cyc - ack_q[0].cyc) : -1); end
    tick(4);
  endtask

  task automatic test_starve();
    bit ok;
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b010};
    clr();
    dout_val = 8'h11;
    bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0042; bus.dma_addr = 16'h2000;
    bus.dma_req = 1'b1; bus.cpu_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_acks(k + 1, 30, ok);
      if (ok && ack_q[k].ack == 3'b001) bus.cpu_req = 1'b0;
      if (k == 5) bus.dma_req = 1'b0;
      total++; if (!ok || ack_q[k].ack !== exp_seq[k])
        begin bad++; $display("FAIL starve_seq[%0d]: got %b want %b", k, ok ? ack_q[k].ack : 3'bx, exp_seq[k]); end
    end
    bus.dma_req = 1'b0; bus.cpu_req = 1'b0;
    tick(4);
  endtask

  task automatic test_cpu_write_ext();
    bit ok;
    logic [26:0] exp_cmd;
    logic [7:0]  exp_rd;
`ifdef RAM_ARB_EXTROM_EN
    exp_cmd = {2'b01, 25'h107FFFF}; exp_rd = 8'h99;
`else
    exp_cmd = {2'b10, 25'h000FFFF}; exp_rd = 8'h11;
`endif
    clr();
    dout_val = 8'h99;
    bus.cpu_we = 1'b1; bus.cpu_addr = 16'hFFFF; bus.cpu_din = 8'h3C;
    bus.ext_sel = 1'b1; bus.ext_addr = 19'h7FFFF;
    bus.cpu_req = 1'b1;
    wait_acks(1, 20, ok);
    bus.cpu_req = 1'b0; bus.ext_sel = 1'b0;
    total++; if (iss_q.size() != 1 || {iss_q[0].we, iss_q[0].rd, iss_q[0].addr} !== exp_cmd)
      begin bad++; $display("FAIL cpu_ext_cmd: got %h want %h", iss_q.size() ? {iss_q[0].we, iss_q[0].rd, iss_q[0].addr} : 27'hx, exp_cmd); end
    total++; if (!ok || ack_q[0].ack !== 3'b001) begin bad++; $display("FAIL cpu_ext_ack: got %b want 001", ok ? ack_q[0].ack : 3'bx); end
    total++; if (!ok || ack_q[0].data !== exp_rd) begin bad++; $display("FAIL cpu_ext_rd_data: got %h want %h", ok ? ack_q[0].data : 8'hx, exp_rd); end
    bus.cpu_we = 1'b0;
    tick(4);
  endtask

  task automatic test_drop_mid();
    bit ok;
    clr();
    dout_val = 8'h5E; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0100;
    bus.cpu_req = 1'b1;
    tick();
    bus.cpu_req = 1'b0;
    wait_acks(1, 20, ok);
    total++; if (!ok || ack_q[0].ack !== 3'b001) begin bad++; $display("FAIL drop_mid_ack: got %b want 001", ok ? ack_q[0].ack : 3'bx); end
    total++; if (!ok || ack_q[0].data !== 8'h5E) begin bad++; $display("FAIL drop_mid_data: got %h want 5e", ok ? ack_q[0].data : 8'hx); end
    tick(4);
    total++; if (iss_q.size() != 1) begin bad++; $display("FAIL drop_mid_issues: got %0d want 1", iss_q.size()); end
  endtask

  task automatic test_stray_ready();
    bit ok; int c0;
    clr();
    resp_en = 1'b0;
    stray_rdy = 1'b1; #1;
    total++; if (bus.ack !== 3'b000) begin bad++; $display("FAIL stray_ack: got %b want 000", bus.ack); end
    tick();
    stray_rdy = 1'b0;
    tick(3);
    total++; if (iss_q.size() != 0 || ack_q.size() != 0)
      begin bad++; $display("FAIL stray_activity: got issues=%0d acks=%0d want 0 0", iss_q.size(), ack_q.size()); end
    resp_en = 1'b1; rdy_dly = 2;
    dout_val = 8'h4D; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0ABC;
    bus.cpu_req = 1'b1; c0 = cyc;
    wait_acks(1, 20, ok);
    bus.cpu_req = 1'b0;
    total++; if (!ok || int'(ack_q[0].cyc) - c0 != 4) begin bad++; $display("FAIL slow_ready_latency: got %0d want 4", ok ? int'(ack_q[0].cyc) - c0 : -1); end
    total++; if (!ok || ack_q[0].data !== 8'h4D) begin bad++; $display("FAIL slow_ready_data: got %h want 4d", ok ? ack_q[0].data : 8'hx); end
    rdy_dly = 0;
    tick(4);
  endtask

  task automatic test_back_to_back();
    bit ok;
    clr();
    dout_val = 8'h21; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    bus.cpu_req = 1'b1;
    wait_acks(3, 30, ok);
    bus.cpu_req = 1'b0;
    total++; if (!ok || ack_q[1].cyc - ack_q[0].cyc != 3 || ack_q[2].cyc - ack_q[1].cyc != 3)
      begin bad++; $display("FAIL b2b_spacing: got %0d,%0d want 3,3", ok ? int'(ack_q[1].cyc - ack_q[0].cyc) : -1, ok ? int'(ack_q[2].cyc - ack_q[1].cyc) : -1); end
    tick(4);
    total++; if (iss_q.size() != 3) begin bad++; $display("FAIL b2b_issues: got %0d want 3", iss_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr();
    resp_en = 1'b0;
    dout_val = 8'h6B; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0777;
    bus.cpu_req = 1'b1;
    tick(2);
    rst_n = 1'b0;
    tick();
    total++; if (bus.ack !== 3'b000 || bus.mem_rd !== 1'b0 || bus.mem_addr !== 25'h0)
      begin bad++; $display("FAIL rst_mid_outputs: got ack=%b rd=%b addr=%h want 000 0 0", bus.ack, bus.mem_rd, bus.mem_addr); end
    resp_en = 1'b1;
    tick();
    clr();
    rst_n = 1'b1;
    wait_acks(1, 20, ok);
    bus.cpu_req = 1'b0;
    total++; if (iss_q.size() != 1 || {iss_q[0].rd, iss_q[0].addr} !== {1'b1, 25'h0000777})
      begin bad++; $display("FAIL rst_mid_reissue: got n=%0d cmd=%h want n=1 %h", iss_q.size(), iss_q.size() ? {iss_q[0].rd, iss_q[0].addr} : 26'hx, {1'b1, 25'h0000777}); end
    total++; if (!ok || ack_q[0].ack !== 3'b001 || ack_q[0].data !== 8'h6B)
      begin bad++; $display("FAIL rst_mid_ack: got %b/%h want 001/6b", ok ? ack_q[0].ack : 3'bx, ok ? ack_q[0].data : 8'hx); end
    tick(4);
  endtask

  initial begin
    bus.ldr_req = 1'b0; bus.ldr_addr = '0; bus.ldr_din = '0;
    bus.dma_req = 1'b0; bus.dma_addr = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.ext_sel = 1'b0; bus.ext_addr = '0;
    test_reset();
    test_cpu_read();
    test_ldr_dma();
    test_starve();
    test_cpu_write_ext();
    test_drop_mid();
    test_stray_ready();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
